hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 141 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use, branch, I/D-miss and halt handling.
// Tracks miss state, a pending redirect target and a saturating stall counter.
module hazard_ctrl #(
  parameter int RA_W = 3,
  parameter int PC_W = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [RA_W-1:0] id_rs,
  input  logic [RA_W-1:0] id_rt,
  input  logic            id_rs_used,
  input  logic            id_rt_used,
  input  logic            ex_memread,
  input  logic [RA_W-1:0] ex_rd,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] branch_pc,
  input  logic            imem_stall,
  input  logic            dmem_stall,
  input  logic            wb_halt,
  output logic            pc_stall,
  output logic            fd_stall,
  output logic            fd_flush,
  output logic            de_bubble,
  output logic            freeze,
  output logic            redir_valid,
  output logic [PC_W-1:0] redir_pc,
  output logic [1:0]      state,
  output logic [15:0]     stall_cnt
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    IMISS = 2'd1,
    DMISS = 2'd2,
    HALT  = 2'd3
  } stateT;

  stateT           cur;
  stateT           nxt;
  logic            redirPend;
  logic            pendNxt;
  logic [PC_W-1:0] redirPc;
  logic [PC_W-1:0] pcNxt;
  logic [15:0]     stallCnt;
  logic            loadUse;
  logic            isHalt;
  logic            dmemHit;
  logic            imissWait;
  logic            redirGo;

  assign loadUse = ex_memread &
    ((id_rs_used & (id_rs == ex_rd)) |
     (id_rt_used & (id_rt == ex_rd)));

  // Mutually exclusive decode terms, highest priority first.
  assign isHalt    = (cur == HALT);
  assign dmemHit   = !isHalt && dmem_stall;
  assign imissWait = (cur == IMISS) && !dmem_stall &&
                     imem_stall;
  assign redirGo   = (cur == IMISS) && !dmem_stall &&
                     !imem_stall && !branch_taken &&
                     redirPend;

  always_comb begin
    pc_stall    = 1'b0;
    fd_stall    = 1'b0;
    fd_flush    = 1'b0;
    de_bubble   = 1'b0;
    freeze      = 1'b0;
    redir_valid = 1'b0;
    nxt         = cur;
    pendNxt     = redirPend;
    pcNxt       = redirPc;
    unique case (1'b1)
      isHalt: begin
        pc_stall  = 1'b1;
        fd_flush  = 1'b1;
        de_bubble = 1'b1;
      end
      dmemHit: begin
        freeze   = 1'b1;
        pc_stall = 1'b1;
        fd_stall = 1'b1;
        nxt      = DMISS;
      end
      imissWait: begin
        pc_stall  = 1'b1;
        fd_flush  = 1'b1;
        de_bubble = branch_taken | loadUse;
        if (branch_taken) begin
          pendNxt = 1'b1;
          pcNxt   = branch_pc;
        end
      end
      redirGo: begin
        fd_flush    = 1'b1;
        redir_valid = 1'b1;
        pendNxt     = 1'b0;
        nxt         = RUN;
      end
      default: begin
        // RUN, DMISS release and IMISS release all decode as RUN.
        pendNxt = 1'b0;
        nxt     = RUN;
        if (branch_taken) begin
          fd_flush  = 1'b1;
          de_bubble = 1'b1;
        end else if (loadUse) begin
          pc_stall  = 1'b1;
          fd_stall  = 1'b1;
          de_bubble = 1'b1;
        end else if (imem_stall) begin
          pc_stall = 1'b1;
          fd_flush = 1'b1;
          nxt      = IMISS;
        end
      end
    endcase
    if (wb_halt) nxt = HALT;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur       <= RUN;
      redirPend <= 1'b0;
      redirPc   <= '0;
      stallCnt  <= 16'h0000;
    end else begin
      cur       <= nxt;
      redirPend <= pendNxt;
      redirPc   <= pcNxt;
      if (pc_stall && !isHalt && stallCnt != 16'hFFFF)
        stallCnt <= stallCnt + 16'h0001;
    end
  end

  assign redir_pc  = redirPc;
  assign state     = cur;
  assign stall_cnt = stallCnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  id_rs, id_rt, ex_rd;
  logic        id_rs_used, id_rt_used, ex_memread;
  logic        branch_taken;
  logic [15:0] branch_pc;
  logic        imem_stall, dmem_stall, wb_halt;
  logic        pc_stall, fd_stall, fd_flush, de_bubble;
  logic        freeze, redir_valid;
  logic [15:0] redir_pc;
  logic [1:0]  state;
  logic [15:0] stall_cnt;

  int nChk  = 0;
  int nPass = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.RA_W(3), .PC_W(16)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
    .ex_memread(ex_memread), .ex_rd(ex_rd),
    .branch_taken(branch_taken), .branch_pc(branch_pc),
    .imem_stall(imem_stall), .dmem_stall(dmem_stall),
    .wb_halt(wb_halt),
    .pc_stall(pc_stall), .fd_stall(fd_stall),
    .fd_flush(fd_flush), .de_bubble(de_bubble),
    .freeze(freeze), .redir_valid(redir_valid),
    .redir_pc(redir_pc), .state(state),
    .stall_cnt(stall_cnt)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    nChk++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got %0h expected %0h",
                  tag, got, exp);
  endtask

  task automatic clrIn();
    id_rs = 0; id_rt = 0; ex_rd = 0;
    id_rs_used = 0; id_rt_used = 0; ex_memread = 0;
    branch_taken = 0; branch_pc = 0;
    imem_stall = 0; dmem_stall = 0; wb_halt = 0;
  endtask

  task automatic cyc();
    @(negedge clk);
    clrIn();
  endtask

  initial begin
    rst = 1'b1;
    clrIn();
    #1;
    check("rst state", state, 0);
    check("rst cnt", stall_cnt, 0);
    check("rst rpc", redir_pc, 0);
    check("rst pcst", pc_stall, 0);
    @(negedge clk);
    rst = 1'b0;

    // load-use on rs
    cyc(); ex_memread = 1; ex_rd = 3; id_rs = 3; id_rs_used = 1;
    #1;
    check("lu pcst", pc_stall, 1);
    check("lu fdst", fd_stall, 1);
    check("lu bub", de_bubble, 1);
    check("lu flush", fd_flush, 0);
    check("lu cnt0", stall_cnt, 0);
    cyc(); #1;
    check("lu off", pc_stall, 0);
    check("lu cnt1", stall_cnt, 1);
    // load-use on rt
    cyc(); ex_memread = 1; ex_rd = 5; id_rt = 5; id_rt_used = 1;
    id_rs = 3; id_rs_used = 1; #1;
    check("lu rt", fd_stall, 1);
    // no match
    cyc(); ex_memread = 1; ex_rd = 4; id_rs = 3; id_rs_used = 1;
    id_rt = 5; id_rt_used = 1; #1;
    check("lu nomatch", pc_stall, 0);
    check("lu cnt2", stall_cnt, 2);
    cyc(); ex_memread = 1; ex_rd = 3; id_rs = 3; #1;
    check("lu unused", pc_stall, 0);
    cyc(); ex_rd = 3; id_rs = 3; id_rs_used = 1; #1;
    check("lu noload", de_bubble, 0);

    // load-use + branch: branch wins
    cyc(); ex_memread = 1; ex_rd = 3; id_rs = 3; id_rs_used = 1;
    branch_taken = 1; branch_pc = 16'h0020; #1;
    check("lub flush", fd_flush, 1);
    check("lub bub", de_bubble, 1);
    check("lub pcst", pc_stall, 0);
    check("lub fdst", fd_stall, 0);

    // imiss 3 cycles, branch in cycle 2
    cyc(); imem_stall = 1; #1;
    check("im1 pcst", pc_stall, 1);
    check("im1 flush", fd_flush, 1);
    check("im1 state", state, 0);
    check("im1 cnt", stall_cnt, 2);
    cyc(); imem_stall = 1; branch_taken = 1;
    branch_pc = 16'h0040; #1;
    check("im2 state", state, 1);
    check("im2 pcst", pc_stall, 1);
    check("im2 bub", de_bubble, 1);
    check("im2 rv", redir_valid, 0);
    cyc(); imem_stall = 1; #1;
    check("im3 rpc", redir_pc, 16'h0040);
    check("im3 bub", de_bubble, 0);
    cyc(); #1;
    check("im4 rv", redir_valid, 1);
    check("im4 rpc", redir_pc, 16'h0040);
    check("im4 flush", fd_flush, 1);
    check("im4 pcst", pc_stall, 0);
    check("im4 cnt", stall_cnt, 5);
    cyc(); #1;
    check("im5 state", state, 0);
    check("im5 rv", redir_valid, 0);

    // imem release coincident with live branch
    cyc(); imem_stall = 1;
    cyc(); imem_stall = 1; branch_taken = 1; branch_pc = 16'h0080;
    cyc(); branch_taken = 1; branch_pc = 16'h0090; #1;
    check("lb flush", fd_flush, 1);
    check("lb bub", de_bubble, 1);
    check("lb pcst", pc_stall, 0);
    check("lb rv", redir_valid, 0);
    cyc(); #1;
    check("lb state", state, 0);
    check("lb rv2", redir_valid, 0);
    check("lb cnt", stall_cnt, 7);

    // dmiss with branch held
    cyc(); dmem_stall = 1; branch_taken = 1; branch_pc = 16'h0100;
    #1;
    check("dm1 frz", freeze, 1);
    check("dm1 flush", fd_flush, 0);
    check("dm1 fdst", fd_stall, 1);
    check("dm1 bub", de_bubble, 0);
    cyc(); dmem_stall = 1; branch_taken = 1; #1;
    check("dm2 state", state, 2);
    check("dm2 frz", freeze, 1);
    check("dm2 flush", fd_flush, 0);
    cyc(); branch_taken = 1; #1;
    check("dm3 state", state, 2);
    check("dm3 frz", freeze, 0);
    check("dm3 flush", fd_flush, 1);
    check("dm3 pcst", pc_stall, 0);
    cyc(); #1;
    check("dm4 state", state, 0);
    check("dm4 cnt", stall_cnt, 9);

    // halt
    cyc(); wb_halt = 1; #1;
    check("h0 pcst", pc_stall, 0);
    check("h0 state", state, 0);
    cyc(); dmem_stall = 1; #1;
    check("h1 state", state, 3);
    check("h1 pcst", pc_stall, 1);
    check("h1 flush", fd_flush, 1);
    check("h1 frz", freeze, 0);
    cyc(); imem_stall = 1;
    cyc(); #1;
    check("h3 state", state, 3);
    check("h3 cnt", stall_cnt, 9);
    #2 rst = 1'b1;
    #1;
    check("hr state", state, 0);
    check("hr cnt", stall_cnt, 0);
    @(negedge clk);
    rst = 1'b0;

    // saturation under continuous imem_stall
    imem_stall = 1;
    repeat (65534) @(posedge clk);
    #1;
    check("sat fffe", stall_cnt, 16'hFFFE);
    repeat (3) @(posedge clk);
    #1;
    check("sat hold", stall_cnt, 16'hFFFF);
    @(negedge clk);
    branch_taken = 1; branch_pc = 16'h1234;
    @(negedge clk);
    branch_taken = 0; #1;
    check("pend rpc", redir_pc, 16'h1234);
    check("pend state", state, 1);
    // reset mid-IMISS drops the pending redirect
    #1 rst = 1'b1;
    #1;
    check("mr state", state, 0);
    check("mr rpc", redir_pc, 0);
    check("mr cnt", stall_cnt, 0);
    @(negedge clk);
    rst = 1'b0; imem_stall = 0; #1;
    check("mr rv", redir_valid, 0);
    check("mr flush", fd_flush, 0);

    $display("%0d/%0d checks passed", nPass, nChk);
    $finish;
  end

endmodule
